// File: rtl/alu_src_fwd_stage.sv
// alu_src_fwd_stage: selects the ALU second operand from one of four sources
// (immediate, register read, EX forward, WB forward), detects load-use
// hazards and registers the chosen operand into a one-entry valid/ready stage.
// Optional build macro ALU_SRC_STALL_CNT_EN adds a saturating 16-bit
// stall_cnt output that counts hazard cycles.
module alu_src_fwd_stage #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              use_imm,
  input  logic [REG_AW-1:0] ra_addr,
  input  logic [WIDTH-1:0]  ar,
  input  logic [WIDTH-1:0]  d,
  input  logic              ex_we,
  input  logic              ex_load,
  input  logic [REG_AW-1:0] ex_addr,
  input  logic [WIDTH-1:0]  ex_data,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [WIDTH-1:0]  wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  src,
  output logic [1:0]        fwd_sel
`ifdef ALU_SRC_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {
    SEL_IMM = 2'd0,
    SEL_AR  = 2'd1,
    SEL_EX  = 2'd2,
    SEL_WB  = 2'd3
  } sel_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_src;
  sel_e             r_sel;

  logic             w_ex_match;
  logic             w_ex_hit;
  logic             w_wb_hit;
  logic             w_hazard;
  logic             w_xfer;
  logic             w_consume;
  logic [WIDTH-1:0] w_operand;
  sel_e             w_sel;

  // Address matches and load-use hazard detection
  always_comb begin
    w_ex_match = ex_we && (ex_addr == ra_addr);
    w_ex_hit   = w_ex_match && !ex_load;
    w_wb_hit   = wb_we && (wb_addr == ra_addr);
    w_hazard   = in_valid && !use_imm && w_ex_match && ex_load;
  end

  // Handshake: accept when no hazard and the slot is empty or being drained
  always_comb begin
    w_consume = (r_state == FULL) && out_ready;
    in_ready  = !w_hazard && ((r_state == EMPTY) || out_ready);
    w_xfer    = in_valid && in_ready;
  end

  // Operand source priority: immediate, EX forward, WB forward, register read
  always_comb begin
    w_operand = ar;
    w_sel     = SEL_AR;
    if (use_imm) begin
      w_operand = d;
      w_sel     = SEL_IMM;
    end else if (w_ex_hit) begin
      w_operand = ex_data;
      w_sel     = SEL_EX;
    end else if (w_wb_hit) begin
      w_operand = wb_data;
      w_sel     = SEL_WB;
    end
  end

  // Pipeline slot: load on transfer, empty on consume-without-transfer; src is kept on drain
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_src   <= '0;
      r_sel   <= SEL_IMM;
    end else if (w_xfer) begin
      r_state <= FULL;
      r_src   <= w_operand;
      r_sel   <= w_sel;
    end else if (w_consume) begin
      r_state <= EMPTY;
    end
  end

  assign out_valid = (r_state == FULL);
  assign src       = r_src;
  assign fwd_sel   = r_sel;

`ifdef ALU_SRC_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Saturating count of hazard cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_hazard && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_alu_src_fwd_stage.sv
// tb_alu_src_fwd_stage: directed, table-driven check of alu_src_fwd_stage
// plus hand-written reset, load-use stall, backpressure and throughput runs.
module tb_alu_src_fwd_stage;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned REG_AW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              use_imm;
  logic [REG_AW-1:0] ra_addr;
  logic [WIDTH-1:0]  ar;
  logic [WIDTH-1:0]  d;
  logic              ex_we;
  logic              ex_load;
  logic [REG_AW-1:0] ex_addr;
  logic [WIDTH-1:0]  ex_data;
  logic              wb_we;
  logic [REG_AW-1:0] wb_addr;
  logic [WIDTH-1:0]  wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  src;
  logic [1:0]        fwd_sel;
`ifdef ALU_SRC_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  alu_src_fwd_stage #(.WIDTH(WIDTH), .REG_AW(REG_AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .use_imm   (use_imm),
    .ra_addr   (ra_addr),
    .ar        (ar),
    .d         (d),
    .ex_we     (ex_we),
    .ex_load   (ex_load),
    .ex_addr   (ex_addr),
    .ex_data   (ex_data),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .src       (src),
    .fwd_sel   (fwd_sel)
`ifdef ALU_SRC_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  typedef struct {
    logic              use_imm;
    logic [REG_AW-1:0] ra;
    logic [WIDTH-1:0]  ar;
    logic [WIDTH-1:0]  d;
    logic              ex_we;
    logic              ex_load;
    logic [REG_AW-1:0] ex_addr;
    logic [WIDTH-1:0]  ex_data;
    logic              wb_we;
    logic [REG_AW-1:0] wb_addr;
    logic [WIDTH-1:0]  wb_data;
    logic [WIDTH-1:0]  exp_src;
    logic [1:0]        exp_sel;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    use_imm   = 1'b0;
    ra_addr   = '0;
    ar        = '0;
    d         = '0;
    ex_we     = 1'b0;
    ex_load   = 1'b0;
    ex_addr   = '0;
    ex_data   = '0;
    wb_we     = 1'b0;
    wb_addr   = '0;
    wb_data   = '0;
    out_ready = 1'b1;
  endtask

  // advance past the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic imm_req(input logic [WIDTH-1:0] val);
    idle();
    in_valid = 1'b1;
    use_imm  = 1'b1;
    d        = val;
  endtask

  initial begin
    // use_imm, ra, ar, d, ex_we, ex_load, ex_addr, ex_data, wb_we, wb_addr, wb_data, exp_src, exp_sel
    vecs[0] = '{1'b1, 3'd3, 16'hAAAA, 16'h1234, 1'b1, 1'b0, 3'd3, 16'h0E0E, 1'b1, 3'd3, 16'h0B0B, 16'h1234, 2'd0};
    vecs[1] = '{1'b0, 3'd2, 16'hAAAA, 16'h1234, 1'b1, 1'b0, 3'd4, 16'h0E0E, 1'b1, 3'd6, 16'h0B0B, 16'hAAAA, 2'd1};
    vecs[2] = '{1'b0, 3'd3, 16'hAAAA, 16'h1234, 1'b1, 1'b0, 3'd3, 16'h0E0E, 1'b1, 3'd3, 16'h0B0B, 16'h0E0E, 2'd2};
    vecs[3] = '{1'b0, 3'd3, 16'hAAAA, 16'h1234, 1'b1, 1'b0, 3'd4, 16'h0E0E, 1'b1, 3'd3, 16'h0B0B, 16'h0B0B, 2'd3};
    vecs[4] = '{1'b0, 3'd3, 16'h1111, 16'h1234, 1'b0, 1'b0, 3'd3, 16'h0E0E, 1'b1, 3'd3, 16'h0B0B, 16'h0B0B, 2'd3};
    vecs[5] = '{1'b0, 3'd3, 16'h2222, 16'h1234, 1'b1, 1'b1, 3'd4, 16'h0E0E, 1'b0, 3'd3, 16'h0B0B, 16'h2222, 2'd1};
    vecs[6] = '{1'b0, 3'd0, 16'h3333, 16'h1234, 1'b1, 1'b0, 3'd0, 16'h00FF, 1'b0, 3'd0, 16'h0B0B, 16'h00FF, 2'd2};
    vecs[7] = '{1'b0, 3'd7, 16'h4444, 16'h1234, 1'b1, 1'b0, 3'd3, 16'hC3C3, 1'b1, 3'd7, 16'h7777, 16'h7777, 2'd3};
    vecs[8] = '{1'b1, 3'd5, 16'h5A5A, 16'hBEEF, 1'b1, 1'b1, 3'd5, 16'h0E0E, 1'b0, 3'd0, 16'h0B0B, 16'hBEEF, 2'd0};

    // Reset with arbitrary inputs offered
    idle();
    rst      = 1'b1;
    in_valid = 1'b1;
    use_imm  = 1'b1;
    d        = 16'hDEAD;
    ar       = 16'hBEEF;
    @(negedge clk);
    tick();
    tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_src", {16'd0, src}, 32'd0);
    chk("rst_fwd_sel", {30'd0, fwd_sel}, 32'd0);
`ifdef ALU_SRC_STALL_CNT_EN
    chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
    rst = 1'b0;
    idle();
    tick();

    // Table-driven source selection / forwarding priority
    for (int i = 0; i < 9; i++) begin
      idle();
      in_valid = 1'b1;
      use_imm  = vecs[i].use_imm;
      ra_addr  = vecs[i].ra;
      ar       = vecs[i].ar;
      d        = vecs[i].d;
      ex_we    = vecs[i].ex_we;
      ex_load  = vecs[i].ex_load;
      ex_addr  = vecs[i].ex_addr;
      ex_data  = vecs[i].ex_data;
      wb_we    = vecs[i].wb_we;
      wb_addr  = vecs[i].wb_addr;
      wb_data  = vecs[i].wb_data;
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      tick();
      chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_src", i), {16'd0, src}, {16'd0, vecs[i].exp_src});
      chk($sformatf("vec%0d_fwd_sel", i), {30'd0, fwd_sel}, {30'd0, vecs[i].exp_sel});
    end

    // Load-use stall: slot holds BEEF from the last vector and drains to a bubble
    idle();
    in_valid = 1'b1;
    ra_addr  = 3'd5;
    ar       = 16'h0000;
    ex_we    = 1'b1;
    ex_load  = 1'b1;
    ex_addr  = 3'd5;
    @(negedge clk);
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("stall_out_valid", {31'd0, out_valid}, 32'd0);
    chk("stall_src_kept", {16'd0, src}, 32'h0000BEEF);
`ifdef ALU_SRC_STALL_CNT_EN
    chk("stall_cnt_1", {16'd0, stall_cnt}, 32'd1);
`endif
    ex_we   = 1'b0;
    ex_load = 1'b0;
    wb_we   = 1'b1;
    wb_addr = 3'd5;
    wb_data = 16'h5555;
    @(negedge clk);
    chk("unstall_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("unstall_out_valid", {31'd0, out_valid}, 32'd1);
    chk("unstall_src", {16'd0, src}, 32'h00005555);
    chk("unstall_fwd_sel", {30'd0, fwd_sel}, 32'd3);
`ifdef ALU_SRC_STALL_CNT_EN
    chk("stall_cnt_hold", {16'd0, stall_cnt}, 32'd1);
`endif

    // Backpressure: hold 0001 for three cycles while a new request waits
    imm_req(16'h0001);
    tick();
    imm_req(16'h9999);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
      tick();
      chk($sformatf("bp%0d_out_valid", c), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp%0d_src", c), {16'd0, src}, 32'h00000001);
      chk($sformatf("bp%0d_fwd_sel", c), {30'd0, fwd_sel}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp_release_src", {16'd0, src}, 32'h00009999);
    chk("bp_release_out_valid", {31'd0, out_valid}, 32'd1);

    // Throughput: eight back-to-back immediates, one per cycle
    for (int k = 0; k < 8; k++) begin
      imm_req(WIDTH'(k));
      @(negedge clk);
      chk($sformatf("tp%0d_in_ready", k), {31'd0, in_ready}, 32'd1);
      tick();
      chk($sformatf("tp%0d_src", k), {16'd0, src}, k);
      chk($sformatf("tp%0d_out_valid", k), {31'd0, out_valid}, 32'd1);
    end
    // Drain with nothing offered: out_valid drops, src retained
    idle();
    tick();
    chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_src_kept", {16'd0, src}, 32'd7);

    // Reset while FULL and held discards the operand
    imm_req(16'h4321);
    tick();
    out_ready = 1'b0;
    rst       = 1'b1;
    tick();
    chk("rst_held_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_held_src", {16'd0, src}, 32'd0);
    rst = 1'b0;

    // Reset asserted during a hazard
    idle();
    in_valid = 1'b1;
    ra_addr  = 3'd2;
    ex_we    = 1'b1;
    ex_load  = 1'b1;
    ex_addr  = 3'd2;
    tick();
`ifdef ALU_SRC_STALL_CNT_EN
    chk("stall_cnt_again", {16'd0, stall_cnt}, 32'd1);
`endif
    rst = 1'b1;
    tick();
    chk("rst_stall_out_valid", {31'd0, out_valid}, 32'd0);
`ifdef ALU_SRC_STALL_CNT_EN
    chk("rst_stall_cnt_clr", {16'd0, stall_cnt}, 32'd0);
`endif
    rst = 1'b0;
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/alu_src_fwd_stage.md
Name: alu_src_fwd_stage

Overview:
- Pipelined, parametrised successor to the ALU source selector.
- Selects the ALU second operand from one of four sources: the register-file read value (AR), the immediate (d), or a forwarded result from the EX or WB stage.
- Registers the selected operand into a one-entry valid/ready pipeline stage.
- Detects load-use hazards and stalls upstream until forwarding can resolve them.
- Sits between the decode/register-read stage and the ALU in the pipelined core.

Parameters:
- WIDTH, 16, operand/data width in bits.
- REG_AW, 3, register address width (8 general registers).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream offers an operand request this cycle.
- in_ready  output  1  stage accepts the request this cycle (combinational).
- use_imm  input  1  0: register path, 1: immediate d.
- ra_addr  input  REG_AW  source register number for the register path.
- ar  input  WIDTH  register-file read data for ra_addr.
- d  input  WIDTH  immediate / displacement value.
- ex_we  input  1  EX stage will write a register.
- ex_load  input  1  EX-stage instruction is a load; its data is not yet available.
- ex_addr  input  REG_AW  EX destination register.
- ex_data  input  WIDTH  EX result (valid only when ex_load=0).
- wb_we  input  1  WB stage writes a register this cycle.
- wb_addr  input  REG_AW  WB destination register.
- wb_data  input  WIDTH  WB write data.
- out_valid  output  1  src holds a valid operand.
- out_ready  input  1  ALU consumes src this cycle.
- src  output  WIDTH  registered selected operand.
- fwd_sel  output  2  source of the held operand: 0 imm, 1 ar, 2 ex, 3 wb.

Behaviour:
- Reset, synchronous and active-high:
  - src=0, out_valid=0, fwd_sel=0.
  - Any held operand is discarded, including one asserted mid-stall or while out_valid=1 and out_ready=0.
- Hazard:
  - hazard = in_valid & ~use_imm & ex_we & ex_load & (ex_addr==ra_addr).
- Handshake:
  - in_ready = ~hazard & (~out_valid | out_ready).
  - A transfer occurs when in_valid & in_ready.
- Operand resolution, in priority order:
  1. use_imm=1 → d, sel 0.
  2. ex_we & ~ex_load & ex_addr==ra_addr → ex_data, sel 2.
  3. wb_we & wb_addr==ra_addr → wb_data, sel 3.
  4. Otherwise ar, sel 1.
- Simultaneous EX and WB match on the same register: EX wins (youngest value).
- Latency: one cycle from transfer to out_valid=1 with src/fwd_sel updated.
- Full throughput: back-to-back transfers with out_ready=1 give one operand per cycle.
- Hold: while out_valid=1 and out_ready=0, src/fwd_sel/out_valid stay stable and in_ready=0.
- Drain:
  - out_valid & out_ready with no transfer in the same cycle → out_valid clears next cycle.
  - src is retained, not zeroed.
- Hazard cycle: no transfer. The stage drains as above, inserting a bubble.
- Hazard clears when the load leaves EX (ex_load=0, or a different ex_addr/ex_we). The load then appears in WB and resolves via the wb_data path.
- The state machine is implicit in out_valid: EMPTY(0) / FULL(1).
  - EMPTY→FULL on transfer.
  - FULL→EMPTY on consume without transfer.
  - FULL→FULL on consume with transfer, or on hold.
- Address comparison is exact over REG_AW bits. Register 0 is not special.

Optional Feature:
- Macro: ALU_SRC_STALL_CNT_EN.
- When defined, adds output port stall_cnt (16 bits):
  - Increments by 1 every cycle hazard=1.
  - Saturates at 16'hFFFF.
  - Cleared by rst.
- When undefined, the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with arbitrary inputs → src=0, out_valid=0, fwd_sel=0. Assert rst while FULL and held → out_valid=0 next cycle.
- Immediate/register select:
  - use_imm=1, d=16'h1234, ar=16'hAAAA → next cycle src=16'h1234, fwd_sel=0.
  - use_imm=0, no forward match → src=16'hAAAA, fwd_sel=1.
- Forward priority:
  - ra_addr=3, ex_we=1, ex_addr=3, ex_data=16'h0E0E, wb_we=1, wb_addr=3, wb_data=16'h0B0B → src=16'h0E0E, fwd_sel=2.
  - Repeat with ex_addr=4 → src=16'h0B0B, fwd_sel=3.
- Load-use stall: ra_addr=5, ex_we=1, ex_load=1, ex_addr=5 → in_ready=0, out_valid=0 after drain, stall_cnt=1 (feature on). Next cycle ex_we=0, wb_we=1, wb_addr=5, wb_data=16'h5555 → transfer, src=16'h5555.
- Backpressure: FULL with src=16'h0001, out_ready=0 for 3 cycles while in_valid=1 → src stable, in_ready=0. out_ready=1 → new operand accepted the same cycle and appears the next cycle.
- Throughput: 8 back-to-back requests with d=0..7, out_ready=1 → src sequence 0..7 on consecutive cycles, no bubbles.
